// File: rtl/nand_wr_pkg.sv
// Shared types, codes and row-address helpers for the NAND page-write
// controller.
package nand_wr_pkg;

    localparam logic [1:0] ST_OK   = 2'd0;
    localparam logic [1:0] ST_FAIL = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    localparam logic [1:0] WS_OK   = 2'd1;
    localparam logic [1:0] WS_FAIL = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK,
        S_CHK_WAIT,
        S_PROG,
        S_PROG_WAIT,
        S_INFO,
        S_INFO_WAIT,
        S_DONE
    } state_t;

    function automatic logic [31:0] pg_of(input logic [31:0] row,
                                          input int pb);
        return row & ((32'd1 << pb) - 32'd1);
    endfunction

    function automatic logic [31:0] blk_of(input logic [31:0] row,
                                           input int pb, input int bb);
        return (row >> pb) & ((32'd1 << bb) - 32'd1);
    endfunction

    // Block+1 wraps inside the block field; upper row bits are kept and
    // the page field is cleared.
    function automatic logic [31:0] next_blk(input logic [31:0] row,
                                             input int pb, input int bb);
        logic [31:0] fld;
        logic [31:0] keep;
        fld  = ((32'd1 << bb) - 32'd1) << pb;
        keep = row & ~(fld | ((32'd1 << pb) - 32'd1));
        return keep | (((blk_of(row, pb, bb) + 32'd1) << pb) & fld);
    endfunction

endpackage

// File: rtl/nand_page_write_ctrl_if.sv
// Request, engine, bad-block-check and RAM signals of the page-write
// controller.
interface nand_page_write_ctrl_if #(
    parameter int ROW_W = 24,
    parameter int CNT_W = 14
);
    logic             en_write;
    logic             end_write;
    logic [1:0]       write_status;
    logic             en_init_flash_addr;
    logic [ROW_W-1:0] init_addr_row;
    logic             end_init_flash_addr;
    logic             en_write_page;
    logic             end_write_page;
    logic [1:0]       write_success;
    logic             blk_chk_req;
    logic             blk_chk_done;
    logic             blk_bad;
    logic [ROW_W-1:0] write_addr_row;
    logic [CNT_W-1:0] write_data_cnt;
    logic [7:0]       write_data;
    logic [CNT_W-1:0] write_ram_addr;
    logic [7:0]       write_ram_dataout;
    logic [15:0]      bad_blk_cnt;

    modport slave (
        input  en_write, en_init_flash_addr, init_addr_row,
        input  end_write_page, write_success, blk_chk_done, blk_bad,
        input  write_data_cnt, write_ram_dataout,
        output end_write, write_status, end_init_flash_addr,
        output en_write_page, blk_chk_req, write_addr_row,
        output write_data, write_ram_addr, bad_blk_cnt
    );

    modport master (
        output en_write, en_init_flash_addr, init_addr_row,
        output end_write_page, write_success, blk_chk_done, blk_bad,
        output write_data_cnt, write_ram_dataout,
        input  end_write, write_status, end_init_flash_addr,
        input  en_write_page, blk_chk_req, write_addr_row,
        input  write_data, write_ram_addr, bad_blk_cnt
    );
endinterface

// File: rtl/nand_wr_data_mux.sv
// Byte source for the page engine: RAM data, spare fill or the
// block-info page contents.
module nand_wr_data_mux
    import nand_wr_pkg::*;
#(
    parameter int PAGE_BITS  = 7,
    parameter int PAGE_BYTES = 8192,
    parameter int CNT_W      = 14
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic [7:0]       ram_data,
    input  logic             info_mode,
    input  logic [7:0]       bbc_lo,
    output logic [CNT_W-1:0] ram_addr,
    output logic [7:0]       data
);
    localparam logic [7:0] PG_CNT = 8'((1 << PAGE_BITS) - 1);

    logic main_area;

    assign main_area = 32'(cnt) < 32'(PAGE_BYTES);

    always_comb begin
        ram_addr = main_area ? cnt : '0;
        data     = 8'h00;
        if (info_mode) begin
            if (cnt == CNT_W'(0))
                data = PG_CNT;
            else if (cnt == CNT_W'(1))
                data = bbc_lo;
        end else begin
            data = main_area ? ram_data : 8'hFF;
        end
    end

endmodule

// File: rtl/nand_page_write_ctrl.sv
// Page-write controller: bad-block skip, retry on next block and
// block-info page in the last page of each block.
module nand_page_write_ctrl
    import nand_wr_pkg::*;
#(
    parameter int ROW_W      = 24,
    parameter int PAGE_BITS  = 7,
    parameter int BLK_BITS   = 12,
    parameter int PAGE_BYTES = 8192,
    parameter int CNT_W      = 14,
    parameter int MAX_RETRY  = 3,
    parameter int INFO_EN    = 1
) (
    input logic clk,
    input logic rst,
    nand_page_write_ctrl_if.slave bus
);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [31:0] LAST_PG = (32'd1 << PAGE_BITS) - 32'd1;
    localparam logic [31:0] BLK_MAX = (32'd1 << BLK_BITS) - 32'd1;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [15:0]      bbc_q, bbc_d;
    logic [1:0]       status_q, status_d;
    logic             ewp_q, ewp_d;
    logic             info_q, info_d;
    logic             ack_q, ack_d;
    logic             chk_q, chk_d;
    logic             end_q;

    logic [31:0]      row32, pg32, blk32;
    logic [ROW_W-1:0] row_nb, row_inc;
    logic [15:0]      bbc_inc;
    logic [RW-1:0]    retry_inc;

    assign row32   = 32'(row_q);
    assign pg32    = pg_of(row32, PAGE_BITS);
    assign blk32   = blk_of(row32, PAGE_BITS, BLK_BITS);
    assign row_nb  = ROW_W'(next_blk(row32, PAGE_BITS, BLK_BITS));
    // With the info page enabled a data page never lands on the last
    // page, so only the page field advances.
    assign row_inc = (INFO_EN != 0)
                   ? ROW_W'((row32 & ~LAST_PG) | ((pg32 + 32'd1) & LAST_PG))
                   : row_q + ROW_W'(1);
    assign bbc_inc   = (bbc_q == 16'hFFFF) ? bbc_q : bbc_q + 16'd1;
    assign retry_inc = retry_q + RW'(1);

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        retry_d  = retry_q;
        bbc_d    = bbc_q;
        status_d = status_q;
        ewp_d    = ewp_q;
        info_d   = info_q;
        ack_d    = 1'b0;
        chk_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.en_init_flash_addr) begin
                    row_d = bus.init_addr_row;
                    ack_d = 1'b1;
                end else if (bus.en_write) begin
                    retry_d = '0;
                    state_d = (pg32 == 32'd0) ? S_CHK : S_PROG;
                end
            end
            S_CHK: begin
                chk_d   = 1'b1;
                state_d = S_CHK_WAIT;
            end
            S_CHK_WAIT: begin
                if (bus.blk_chk_done) begin
                    if (!bus.blk_bad) begin
                        state_d = S_PROG;
                    end else if (blk32 == BLK_MAX) begin
                        status_d = ST_FULL;
                        state_d  = S_DONE;
                    end else begin
                        bbc_d   = bbc_inc;
                        row_d   = row_nb;
                        state_d = S_CHK;
                    end
                end
            end
            S_PROG: begin
                ewp_d   = 1'b1;
                info_d  = 1'b0;
                state_d = S_PROG_WAIT;
            end
            S_PROG_WAIT: begin
                if (bus.end_write_page) begin
                    ewp_d = 1'b0;
                    if (bus.write_success == WS_OK) begin
                        row_d = row_inc;
                        if (INFO_EN != 0 &&
                            pg_of(32'(row_inc), PAGE_BITS) == LAST_PG) begin
                            state_d = S_INFO;
                        end else begin
                            status_d = ST_OK;
                            state_d  = S_DONE;
                        end
                    end else begin
                        retry_d = retry_inc;
                        bbc_d   = bbc_inc;
                        row_d   = row_nb;
                        if (retry_inc == RW'(MAX_RETRY)) begin
                            status_d = ST_FAIL;
                            state_d  = S_DONE;
                        end else begin
                            state_d = S_CHK;
                        end
                    end
                end
            end
            S_INFO: begin
                info_d  = 1'b1;
                ewp_d   = 1'b1;
                state_d = S_INFO_WAIT;
            end
            S_INFO_WAIT: begin
                // Data page is already committed; info result is advisory.
                if (bus.end_write_page) begin
                    ewp_d    = 1'b0;
                    row_d    = row_nb;
                    status_d = ST_OK;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            retry_q  <= '0;
            bbc_q    <= '0;
            status_q <= '0;
            ewp_q    <= 1'b0;
            info_q   <= 1'b0;
            ack_q    <= 1'b0;
            chk_q    <= 1'b0;
            end_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            retry_q  <= retry_d;
            bbc_q    <= bbc_d;
            status_q <= status_d;
            ewp_q    <= ewp_d;
            info_q   <= info_d;
            ack_q    <= ack_d;
            chk_q    <= chk_d;
            end_q    <= (state_d == S_DONE);
        end
    end

    assign bus.end_write           = end_q;
    assign bus.write_status        = status_q;
    assign bus.end_init_flash_addr = ack_q;
    assign bus.en_write_page       = ewp_q;
    assign bus.blk_chk_req         = chk_q;
    assign bus.write_addr_row      = row_q;
    assign bus.bad_blk_cnt         = bbc_q;

    nand_wr_data_mux #(
        .PAGE_BITS  (PAGE_BITS),
        .PAGE_BYTES (PAGE_BYTES),
        .CNT_W      (CNT_W)
    ) u_mux (
        .cnt       (bus.write_data_cnt),
        .ram_data  (bus.write_ram_dataout),
        .info_mode (info_q),
        .bbc_lo    (bbc_q[7:0]),
        .ram_addr  (bus.write_ram_addr),
        .data      (bus.write_data)
    );

endmodule

// File: tb/tb_nand_page_write_ctrl.sv
// Bench for nand_page_write_ctrl: engine/checker responders plus a
// request-level reference model.
module tb_nand_page_write_ctrl;

    logic clk;
    logic rst;

    nand_page_write_ctrl_if #(.ROW_W(24), .CNT_W(14)) bus ();

    nand_page_write_ctrl #(
        .ROW_W(24), .PAGE_BITS(7), .BLK_BITS(12), .PAGE_BYTES(8192),
        .CNT_W(14), .MAX_RETRY(3), .INFO_EN(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.write_ram_dataout = bus.write_ram_addr[7:0] ^ 8'h5A;

    typedef struct {
        logic [23:0] row;
        logic [7:0]  b0, b1, bx, bs;
        logic [13:0] ax, sa;
        int          x;
    } rec_t;

    int   total = 0;
    int   bad = 0;
    rec_t rec_q[$];
    int   chk_q[$];
    int   eng_plan[$];
    bit   eng_hold = 1'b0;
    bit   bad_map [0:4095];
    int   ew_count = 0;
    logic [1:0] ew_status = 2'd0;

    // reference model results
    int          m_plan[$];
    logic [23:0] m_rows[$];
    bit          m_info[$];
    int          m_b1[$];
    int          m_status, m_nchk, m_bbc;
    logic [23:0] m_row;

    function automatic logic [7:0] ram_of(input int a);
        return 8'(a) ^ 8'h5A;
    endfunction

    function automatic logic [23:0] mk(input int hi, input int blk,
                                       input int pg);
        return 24'((hi << 19) | (blk << 7) | pg);
    endfunction

    task automatic model_req(input logic [23:0] row);
        int hi, blk, pg, retry, p, o;
        bit chk, done;
        hi = int'(row) >> 19;
        blk = (int'(row) >> 7) % 4096;
        pg = int'(row) % 128;
        retry = 0; p = 0; done = 0;
        chk = (pg == 0);
        m_rows.delete(); m_info.delete(); m_b1.delete();
        m_nchk = 0;
        while (!done) begin
            if (chk) begin
                m_nchk++;
                if (bad_map[blk]) begin
                    if (blk == 4095) begin
                        m_status = 2; done = 1;
                    end else begin
                        m_bbc = (m_bbc < 65535) ? m_bbc + 1 : m_bbc;
                        blk++; pg = 0;
                    end
                end else chk = 0;
            end else begin
                m_rows.push_back(mk(hi, blk, pg));
                m_info.push_back(0); m_b1.push_back(0);
                o = (p < m_plan.size()) ? m_plan[p] : 1; p++;
                if (o == 1) begin
                    pg++;
                    if (pg == 127) begin
                        m_rows.push_back(mk(hi, blk, 127));
                        m_info.push_back(1); m_b1.push_back(m_bbc % 256);
                        p++;
                        blk = (blk + 1) % 4096; pg = 0;
                    end
                    m_status = 0; done = 1;
                end else begin
                    retry++;
                    m_bbc = (m_bbc < 65535) ? m_bbc + 1 : m_bbc;
                    blk = (blk + 1) % 4096; pg = 0;
                    if (retry == 3) begin m_status = 1; done = 1; end
                    else chk = 1;
                end
            end
        end
        m_row = mk(hi, blk, pg);
    endtask

    // page engine
    initial begin
        rec_t r;
        int d, x;
        bus.end_write_page = 1'b0;
        bus.write_success = 2'd0;
        bus.write_data_cnt = '0;
        forever begin
            @(negedge clk);
            if (bus.en_write_page === 1'b1) begin
                r.row = bus.write_addr_row;
                x = $urandom_range(2, 8191); r.x = x;
                bus.write_data_cnt = 14'd0; #1 r.b0 = bus.write_data;
                bus.write_data_cnt = 14'd1; #1 r.b1 = bus.write_data;
                bus.write_data_cnt = 14'(x); #1 r.bx = bus.write_data;
                r.ax = bus.write_ram_addr;
                bus.write_data_cnt = 14'(8192 + $urandom_range(0, 8191));
                #1 r.bs = bus.write_data; r.sa = bus.write_ram_addr;
                bus.write_data_cnt = 14'd0;
                rec_q.push_back(r);
                d = $urandom_range(0, 3);
                repeat (d) @(negedge clk);
                while (eng_hold && bus.en_write_page) @(negedge clk);
                if (bus.en_write_page) begin
                    bus.write_success = (eng_plan.size() > 0)
                        ? 2'(eng_plan.pop_front()) : 2'd1;
                    bus.end_write_page = 1'b1;
                    @(negedge clk);
                    bus.end_write_page = 1'b0;
                    bus.write_success = 2'd0;
                end
            end
        end
    end

    // bad-block checker
    initial begin
        int cb, d2;
        bus.blk_chk_done = 1'b0;
        bus.blk_bad = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.blk_chk_req === 1'b1) begin
                cb = int'(bus.write_addr_row[18:7]);
                chk_q.push_back(cb);
                d2 = $urandom_range(0, 2);
                repeat (d2) @(negedge clk);
                bus.blk_bad = bad_map[cb];
                bus.blk_chk_done = 1'b1;
                @(negedge clk);
                bus.blk_chk_done = 1'b0;
                bus.blk_bad = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.end_write === 1'b1) begin
                ew_count++;
                ew_status = bus.write_status;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic clear_bad();
        for (int i = 0; i < 4096; i++) bad_map[i] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; m_bbc = 0;
    endtask

    task automatic do_init(input logic [23:0] row);
        bit seen;
        seen = 0;
        @(negedge clk);
        bus.en_init_flash_addr = 1'b1;
        bus.init_addr_row = row;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = bus.end_init_flash_addr;
        end
        bus.en_init_flash_addr = 1'b0;
        @(negedge clk);
        total++;
        if (!seen || bus.end_init_flash_addr !== 1'b0) begin
            bad++;
            $display("FAIL init_ack: seen=%0d ack_after_drop=%b want 1/0",
                     seen, bus.end_init_flash_addr);
        end
    endtask

    task automatic do_write(output logic [1:0] st, output int pulses);
        int c0;
        c0 = ew_count;
        @(negedge clk); bus.en_write = 1'b1;
        @(negedge clk); bus.en_write = 1'b0;
        for (int i = 0; i < 4000 && ew_count == c0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        st = ew_status;
        pulses = ew_count - c0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({bus.end_write, bus.write_status, bus.end_init_flash_addr,
             bus.en_write_page, bus.blk_chk_req} !== 6'd0) begin
            bad++;
            $display("FAIL reset_ctl: got %b want 0", {bus.end_write,
                bus.write_status, bus.end_init_flash_addr,
                bus.en_write_page, bus.blk_chk_req});
        end
        total++;
        if (bus.write_addr_row !== 24'd0 || bus.bad_blk_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_regs: row=%h bbc=%0d want 0/0",
                     bus.write_addr_row, bus.bad_blk_cnt);
        end
    endtask

    task automatic test_basic();
        logic [1:0] st; int n;
        clear_bad(); eng_plan = '{1};
        do_init(24'h000180);
        rec_q.delete(); chk_q.delete();
        do_write(st, n);
        total++;
        if (n != 1 || st !== 2'd0) begin
            bad++; $display("FAIL basic_end: pulses=%0d st=%0d want 1/0", n, st);
        end
        total++;
        if (chk_q.size() != 1) begin
            bad++; $display("FAIL basic_chk: got %0d checks want 1", chk_q.size());
        end
        total++;
        if (rec_q.size() != 1) begin
            bad++; $display("FAIL basic_progs: got %0d want 1", rec_q.size());
        end else begin
            total++;
            if (rec_q[0].row !== 24'h000180) begin
                bad++; $display("FAIL basic_row: got %h want 000180", rec_q[0].row);
            end
            total++;
            if (rec_q[0].b0 !== 8'h5A || rec_q[0].bx !== ram_of(rec_q[0].x) ||
                rec_q[0].ax !== 14'(rec_q[0].x)) begin
                bad++; $display("FAIL basic_data: b0=%h bx=%h ax=%0d x=%0d",
                    rec_q[0].b0, rec_q[0].bx, rec_q[0].ax, rec_q[0].x);
            end
            total++;
            if (rec_q[0].bs !== 8'hFF || rec_q[0].sa !== 14'd0) begin
                bad++; $display("FAIL basic_spare: byte=%h addr=%0d want FF/0",
                    rec_q[0].bs, rec_q[0].sa);
            end
        end
        total++;
        if (bus.write_addr_row !== 24'h000181) begin
            bad++; $display("FAIL basic_next: got %h want 000181", bus.write_addr_row);
        end
    endtask

    task automatic test_bad_skip();
        logic [1:0] st; int n;
        clear_bad(); bad_map[3] = 1; bad_map[4] = 1; eng_plan = '{1};
        do_init(24'h000180);
        rec_q.delete(); chk_q.delete();
        do_write(st, n);
        total++;
        if (n != 1 || st !== 2'd0 || bus.bad_blk_cnt !== 16'd2) begin
            bad++; $display("FAIL skip_end: pulses=%0d st=%0d bbc=%0d want 1/0/2",
                n, st, bus.bad_blk_cnt);
        end
        total++;
        if (chk_q.size() != 3 || rec_q.size() != 1) begin
            bad++; $display("FAIL skip_counts: checks=%0d progs=%0d want 3/1",
                chk_q.size(), rec_q.size());
        end else begin
            total++;
            if (chk_q[1] != 4 || chk_q[2] != 5 || rec_q[0].row !== 24'h000280) begin
                bad++; $display("FAIL skip_rows: blk=%0d,%0d row=%h want 4,5,000280",
                    chk_q[1], chk_q[2], rec_q[0].row);
            end
        end
    endtask

    task automatic test_info();
        logic [1:0] st; int n;
        clear_bad(); eng_plan = '{1, 1};
        do_init(24'h0002FE);
        rec_q.delete(); chk_q.delete();
        do_write(st, n);
        total++;
        if (n != 1 || st !== 2'd0 || chk_q.size() != 0) begin
            bad++; $display("FAIL info_end: pulses=%0d st=%0d checks=%0d want 1/0/0",
                n, st, chk_q.size());
        end
        total++;
        if (rec_q.size() != 2) begin
            bad++; $display("FAIL info_progs: got %0d want 2", rec_q.size());
        end else begin
            total++;
            if (rec_q[0].row !== 24'h0002FE || rec_q[1].row !== 24'h0002FF) begin
                bad++; $display("FAIL info_rows: got %h,%h want 0002FE,0002FF",
                    rec_q[0].row, rec_q[1].row);
            end
            total++;
            if (rec_q[1].b0 !== 8'h7F || rec_q[1].b1 !== 8'h02 ||
                rec_q[1].bx !== 8'h00 || rec_q[1].bs !== 8'h00) begin
                bad++; $display("FAIL info_bytes: %h %h %h %h want 7F 02 00 00",
                    rec_q[1].b0, rec_q[1].b1, rec_q[1].bx, rec_q[1].bs);
            end
        end
        total++;
        if (bus.write_addr_row !== 24'h000300) begin
            bad++; $display("FAIL info_next: got %h want 000300", bus.write_addr_row);
        end
    endtask

    task automatic test_retry();
        logic [1:0] st; int n;
        clear_bad(); eng_plan = '{2, 0, 2};
        do_init(24'h000500);
        rec_q.delete(); chk_q.delete();
        do_write(st, n);
        total++;
        if (n != 1 || st !== 2'd1 || bus.bad_blk_cnt !== 16'd5) begin
            bad++; $display("FAIL retry_end: pulses=%0d st=%0d bbc=%0d want 1/1/5",
                n, st, bus.bad_blk_cnt);
        end
        total++;
        if (rec_q.size() != 3 || chk_q.size() != 3) begin
            bad++; $display("FAIL retry_counts: progs=%0d checks=%0d want 3/3",
                rec_q.size(), chk_q.size());
        end else begin
            total++;
            if (rec_q[0].row !== 24'h000500 || rec_q[1].row !== 24'h000580 ||
                rec_q[2].row !== 24'h000600) begin
                bad++; $display("FAIL retry_rows: %h %h %h want 000500 000580 000600",
                    rec_q[0].row, rec_q[1].row, rec_q[2].row);
            end
        end
        total++;
        if (bus.write_addr_row !== 24'h000680) begin
            bad++; $display("FAIL retry_next: got %h want 000680", bus.write_addr_row);
        end
    endtask

    task automatic test_full();
        logic [1:0] st; int n;
        clear_bad(); bad_map[4095] = 1; eng_plan = '{1};
        do_init(24'h87FF80);
        rec_q.delete(); chk_q.delete();
        do_write(st, n);
        total++;
        if (n != 1 || st !== 2'd2) begin
            bad++; $display("FAIL full_end: pulses=%0d st=%0d want 1/2", n, st);
        end
        total++;
        if (rec_q.size() != 0 || bus.bad_blk_cnt !== 16'd5 ||
            bus.write_addr_row !== 24'h87FF80) begin
            bad++; $display("FAIL full_state: progs=%0d bbc=%0d row=%h want 0/5/87FF80",
                rec_q.size(), bus.bad_blk_cnt, bus.write_addr_row);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] st; int n, c0;
        bit seen;
        clear_bad(); eng_plan.delete(); eng_hold = 1'b1;
        do_init(24'h000400);
        c0 = ew_count; seen = 0;
        @(negedge clk); bus.en_write = 1'b1;
        @(negedge clk); bus.en_write = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = bus.en_write_page;
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL mid_prog: en_write_page=0 want 1");
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.en_write_page, bus.end_write, bus.write_status,
             bus.blk_chk_req, bus.end_init_flash_addr} !== 6'd0 ||
            bus.write_addr_row !== 24'd0 || bus.bad_blk_cnt !== 16'd0) begin
            bad++; $display("FAIL mid_reset: ewp=%b row=%h bbc=%0d want 0",
                bus.en_write_page, bus.write_addr_row, bus.bad_blk_cnt);
        end
        rst = 1'b0; m_bbc = 0; eng_hold = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (ew_count != c0) begin
            bad++; $display("FAIL mid_noend: got %0d pulses want 0", ew_count - c0);
        end
        eng_plan = '{1};
        do_init(24'h000400);
        rec_q.delete(); chk_q.delete();
        do_write(st, n);
        total++;
        if (n != 1 || st !== 2'd0 || bus.write_addr_row !== 24'h000401) begin
            bad++; $display("FAIL mid_after: pulses=%0d st=%0d row=%h want 1/0/000401",
                n, st, bus.write_addr_row);
        end
    endtask

    task automatic test_init_priority();
        int c0;
        bit seen;
        c0 = ew_count; seen = 0;
        rec_q.delete(); chk_q.delete();
        @(negedge clk);
        bus.en_init_flash_addr = 1'b1; bus.en_write = 1'b1;
        bus.init_addr_row = 24'h000A80;
        @(negedge clk); bus.en_write = 1'b0;
        seen = bus.end_init_flash_addr;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.end_init_flash_addr;
        end
        bus.en_init_flash_addr = 1'b0;
        repeat (15) @(negedge clk);
        total++;
        if (!seen || ew_count != c0 || rec_q.size() != 0 || chk_q.size() != 0) begin
            bad++; $display("FAIL prio: ack=%0d ends=%0d progs=%0d checks=%0d want 1/0/0/0",
                seen, ew_count - c0, rec_q.size(), chk_q.size());
        end
        total++;
        if (bus.write_addr_row !== 24'h000A80) begin
            bad++; $display("FAIL prio_row: got %h want 000A80", bus.write_addr_row);
        end
    endtask

    task automatic test_random();
        logic [1:0] st; int n, hi, blk, pg, v;
        logic [23:0] row;
        for (int it = 0; it < 30; it++) begin
            clear_bad();
            hi = $urandom_range(0, 31);
            v = $urandom_range(0, 5);
            blk = (v == 0) ? 4095 : (v == 1) ? 4094 : $urandom_range(0, 4095);
            v = $urandom_range(0, 4);
            pg = (v < 2) ? 0 : (v == 2) ? 126 : $urandom_range(1, 126);
            for (int k = 0; k < 5; k++)
                if ($urandom_range(0, 2) == 0) bad_map[(blk + k) % 4096] = 1'b1;
            m_plan.delete();
            for (int k = 0; k < 5; k++) begin
                v = $urandom_range(0, 3);
                m_plan.push_back((v == 0) ? 0 : (v == 1) ? 2 : 1);
            end
            eng_plan = m_plan;
            row = mk(hi, blk, pg);
            do_init(row);
            model_req(row);
            rec_q.delete(); chk_q.delete();
            do_write(st, n);
            total++;
            if (n != 1 || st !== 2'(m_status)) begin
                bad++; $display("FAIL rnd%0d_end: pulses=%0d st=%0d want 1/%0d",
                    it, n, st, m_status);
            end
            total++;
            if (bus.write_addr_row !== m_row || bus.bad_blk_cnt !== 16'(m_bbc)) begin
                bad++; $display("FAIL rnd%0d_regs: row=%h bbc=%0d want %h/%0d",
                    it, bus.write_addr_row, bus.bad_blk_cnt, m_row, m_bbc);
            end
            total++;
            if (chk_q.size() != m_nchk || rec_q.size() != m_rows.size()) begin
                bad++; $display("FAIL rnd%0d_counts: checks=%0d progs=%0d want %0d/%0d",
                    it, chk_q.size(), rec_q.size(), m_nchk, m_rows.size());
            end
            for (int i = 0; i < rec_q.size() && i < m_rows.size(); i++) begin
                total++;
                if (rec_q[i].row !== m_rows[i]) begin
                    bad++; $display("FAIL rnd%0d_row%0d: got %h want %h",
                        it, i, rec_q[i].row, m_rows[i]);
                end
                total++;
                if (m_info[i]) begin
                    if (rec_q[i].b0 !== 8'h7F || rec_q[i].b1 !== 8'(m_b1[i]) ||
                        rec_q[i].bx !== 8'h00 || rec_q[i].bs !== 8'h00) begin
                        bad++; $display("FAIL rnd%0d_info%0d: %h %h %h %h want 7F %h 00 00",
                            it, i, rec_q[i].b0, rec_q[i].b1, rec_q[i].bx,
                            rec_q[i].bs, 8'(m_b1[i]));
                    end
                end else begin
                    if (rec_q[i].b0 !== 8'h5A || rec_q[i].bx !== ram_of(rec_q[i].x) ||
                        rec_q[i].bs !== 8'hFF || rec_q[i].sa !== 14'd0) begin
                        bad++; $display("FAIL rnd%0d_data%0d: %h %h %h sa=%0d want 5A %h FF 0",
                            it, i, rec_q[i].b0, rec_q[i].bx, rec_q[i].bs,
                            rec_q[i].sa, ram_of(rec_q[i].x));
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.en_write = 1'b0;
        bus.en_init_flash_addr = 1'b0;
        bus.init_addr_row = '0;
        m_bbc = 0;
        test_reset();
        test_basic();
        test_bad_skip();
        test_info();
        test_retry();
        test_full();
        test_reset_mid();
        test_init_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
